// File: rtl/demux_sel_sequencer.sv
// Serial-bit sequencer driving a 1x8 demux: one start sweeps the enabled
// channels in ascending order, holding each bit for DWELL cycles.
module demux_sel_sequencer #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3,
  parameter int DWELL  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic              in,
  output logic [SEL_W-1:0]  sel,
  output logic              strobe,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DWELL,
    S_DONE
  } state_t;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_CH-1:0]  r_mask;
  logic [SEL_W-1:0]   r_sel;
  logic               r_bit;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_first_any;
  logic [SEL_W-1:0]   w_first_idx;
  logic               w_next_any;
  logic [SEL_W-1:0]   w_next_idx;
  logic               w_last;

  // Descending scans leave the lowest qualifying index in the result.
  always_comb begin
    w_first_any = 1'b0;
    w_first_idx = '0;
    w_next_any  = 1'b0;
    w_next_idx  = r_sel;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_first_any = 1'b1;
        w_first_idx = SEL_W'(i);
      end
      if (r_mask[i] && (i > int'(r_sel))) begin
        w_next_any = 1'b1;
        w_next_idx = SEL_W'(i);
      end
    end
  end

  assign w_last = (r_state == S_DWELL) && (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = w_first_any ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (bit_valid) w_state_nxt = S_DWELL;
      end
      S_DWELL: begin
        if (w_last) w_state_nxt = w_next_any ? S_WAIT : S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_sel   <= '0;
      r_bit   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask <= ch_mask;
            r_sel  <= w_first_idx;
          end
        end
        S_WAIT: begin
          if (bit_valid) begin
            r_bit <= bit_in;
            r_cnt <= '0;
          end
        end
        S_DWELL: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last && w_next_any) r_sel <= w_next_idx;
        end
        S_DONE: begin
          r_sel <= '0;
        end
        default: r_sel <= '0;
      endcase
    end
  end

  assign bit_ready  = (r_state == S_WAIT);
  assign busy       = (r_state == S_WAIT) || (r_state == S_DWELL);
  assign frame_done = (r_state == S_DONE);
  assign in         = (r_state == S_DWELL) && r_bit;
  assign strobe     = w_last;
  assign sel        = r_sel;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Scoreboard bench for demux_sel_sequencer: directed frames, stalls,
// mid-frame reset and ignored start requests.
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ch_mask = '0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic       in;
  logic [2:0] sel;
  logic       strobe;
  logic       busy;
  logic       frame_done;

  demux_sel_sequencer #(.NUM_CH(8), .SEL_W(3), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .in(in), .sel(sel), .strobe(strobe), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       done;
    logic [2:0] sel;
    logic       b;
  } exp_t;

  exp_t sbq[$];
  exp_t m_e;
  logic [7:0] m_y;
  int total = 0;
  int bad = 0;

  int r_done, r_hs, r_strb, r_rdy_after, r_busy;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe / frame_done must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && (strobe || frame_done)) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", {30'd0, strobe, frame_done}, 32'd0);
      end else begin
        m_e = sbq.pop_front();
        chk("sb_kind", {31'd0, frame_done}, {31'd0, m_e.done});
        if (!m_e.done) begin
          chk("sb_sel", {29'd0, sel}, {29'd0, m_e.sel});
          chk("sb_in", {31'd0, in}, {31'd0, m_e.b});
          m_y = 8'(in) << sel;
          chk("sb_demux_y", {31'd0, m_y[m_e.sel]}, {31'd0, m_e.b});
        end
      end
    end
  end

  task automatic outs_zero(input string name);
    chk(name, {24'd0, bit_ready, in, sel, strobe, busy, frame_done}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] mask, input logic [7:0] bits,
                           input int stall_idx, input int stall_n,
                           input int start_at, input int rst_at);
    logic tx[$];
    int   ch[$];
    exp_t e;
    int   idx, stalled, cyc, n;
    bit   aborted;
    tx = {};
    ch = {};
    idx = 0; stalled = 0; aborted = 0;
    r_done = -1; r_hs = 0; r_strb = 0; r_rdy_after = 0; r_busy = 0;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) begin
        tx.push_back(bits[k]);
        ch.push_back(k);
        e.done = 1'b0; e.sel = 3'(k); e.b = bits[k];
        sbq.push_back(e);
      end
    end
    e.done = 1'b1; e.sel = '0; e.b = 1'b0;
    sbq.push_back(e);
    n = tx.size();
    @(negedge clk);
    start = 1'b1;
    ch_mask = mask;
    @(negedge clk);
    start = 1'b0;
    ch_mask = ~mask;
    for (cyc = 1; cyc < 200; cyc++) begin
      if (cyc == rst_at) begin
        chk("pre_rst_sel", {29'd0, sel}, 32'd3);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 outs_zero("async_rst_outs");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      if (frame_done) begin
        r_done = cyc;
        break;
      end
      if (busy) r_busy++;
      start = (cyc == start_at);
      bit_valid = 1'b1;
      if (bit_ready && idx == stall_idx && stalled < stall_n) begin
        bit_valid = 1'b0;
        stalled++;
        chk("stall_sel", {29'd0, sel}, 32'(ch[idx]));
        chk("stall_in", {31'd0, in}, 32'd0);
        chk("stall_strobe", {31'd0, strobe}, 32'd0);
      end
      bit_in = (idx < n) ? tx[idx] : 1'b0;
      if (bit_ready && idx >= n) r_rdy_after++;
      if (bit_ready && bit_valid) begin
        r_hs++;
        idx++;
      end
      if (strobe) r_strb++;
      @(negedge clk);
    end
    start = 1'b0;
    bit_valid = 1'b0;
    if (!aborted) begin
      if (r_done < 0) begin
        total++; bad++;
        $display("FAIL frame_timeout: no frame_done within %0d cycles", cyc);
      end
      // start presented in the DONE cycle must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse_1cyc", {31'd0, frame_done}, 32'd0);
      chk("idle_sel", {29'd0, sel}, 32'd0);
      @(negedge clk);
      outs_zero("idle_after_frame");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom);
      ch_mask = 8'($urandom);
      bit_in = 1'($urandom);
      bit_valid = 1'($urandom);
      #1 outs_zero("rst_hold_outs");
    end
    start = 1'b0; ch_mask = '0; bit_in = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    outs_zero("post_rst_idle");

    // Full mask, bits 1,0,1,1,0,0,1,0 on channels 0..7
    run_frame(8'hFF, 8'h4D, -1, 0, -1, -1);
    chk("ff_done_cyc", 32'(r_done), 32'd41);
    chk("ff_handshakes", 32'(r_hs), 32'd8);
    chk("ff_strobes", 32'(r_strb), 32'd8);
    chk("ff_busy_cycles", 32'(r_busy), 32'd40);

    // Sparse mask: channels 2, 5, 7
    run_frame(8'b1010_0100, 8'b0010_0100, -1, 0, -1, -1);
    chk("sp_done_cyc", 32'(r_done), 32'd16);
    chk("sp_handshakes", 32'(r_hs), 32'd3);
    chk("sp_strobes", 32'(r_strb), 32'd3);
    chk("sp_ready_after", 32'(r_rdy_after), 32'd0);

    // Empty mask
    run_frame(8'h00, 8'hFF, -1, 0, -1, -1);
    chk("zero_done_cyc", 32'(r_done), 32'd1);
    chk("zero_ready", 32'(r_rdy_after), 32'd0);
    chk("zero_strobes", 32'(r_strb), 32'd0);
    chk("zero_busy", 32'(r_busy), 32'd0);

    // Stall 6 cycles in WAIT_BIT of channel 1
    run_frame(8'h03, 8'h02, 1, 6, -1, -1);
    chk("stall_done_cyc", 32'(r_done), 32'd17);
    chk("stall_strobes", 32'(r_strb), 32'd2);

    // Reset during DWELL of channel 3, then a frame with a start while busy
    run_frame(8'hFF, 8'hA5, -1, 0, -1, 18);
    repeat (3) begin
      @(negedge clk);
      outs_zero("post_abort_idle");
    end
    run_frame(8'hFF, 8'h3C, -1, 0, 10, -1);
    chk("rst2_done_cyc", 32'(r_done), 32'd41);
    chk("rst2_strobes", 32'(r_strb), 32'd8);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
